// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares one single-port SDRAM controller between the cartridge PRG and CHR
//   buses. One access is in flight at a time. Grants are round robin. Each port
//   keeps a one-entry read-hit register (tag/valid/rdata), so a repeated read of
//   the same address completes without touching SDRAM. The cartridge reset
//   output is held until the controller first reports ready.
//
// Ports
//   clk_sys, rst            : system clock, synchronous active-high reset
//   rst_out                 : cartridge reset, released on first mem_ready
//   prg_* / chr_*           : requester ports (level req, one-cycle ack)
//                             req, addr, wren, wdata in; rdata, ack out
//   mem_address, mem_req,
//   mem_wren, to_mem        : controller command side (mem_req is the strobe)
//   from_mem, mem_ready     : controller read data and idle/done flag

// Per-port read-hit register. Holds the last read data of its port and the
// address it came from; a write to that address from either port drops it.
module sdram_port_slot #(
    parameter int ADDR_W = 21
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wren,
    input  logic              ack,
    input  logic              fill,
    input  logic              inval,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        fill_data,
    output logic              elig,
    output logic              hit,
    output logic [7:0]        rdata
);
    logic              valid;
    logic [ADDR_W-1:0] tag;

    // A request still high during its own ack cycle is stale, not a new one.
    assign elig = req & ~ack;
    assign hit  = elig & ~wren & valid & (addr == tag);

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            rdata <= '0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= mem_addr;
            rdata <= fill_data;
        end else if (inval && (tag == mem_addr)) begin
            valid <= 1'b0;
        end
    end
endmodule

module sdram_port_arbiter #(
    parameter int ADDR_W = 21
) (
    input  logic              clk_sys,
    input  logic              rst,
    output logic              rst_out,
    input  logic              prg_req,
    input  logic [ADDR_W-1:0] prg_addr,
    input  logic              prg_wren,
    input  logic [7:0]        prg_wdata,
    output logic [7:0]        prg_rdata,
    output logic              prg_ack,
    input  logic              chr_req,
    input  logic [ADDR_W-1:0] chr_addr,
    input  logic              chr_wren,
    input  logic [7:0]        chr_wdata,
    output logic [7:0]        chr_rdata,
    output logic              chr_ack,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_req,
    output logic              mem_wren,
    output logic [7:0]        to_mem,
    input  logic [7:0]        from_mem,
    input  logic              mem_ready
);
    typedef enum logic [2:0] {INIT, IDLE, REQ, SETTLE, WAIT, DONE} state_t;

    // Port index 0 = PRG, 1 = CHR.
    localparam int NUM_PORTS = 2;

    state_t state, state_nxt;

    logic [NUM_PORTS-1:0]             req_v, wren_v, elig, hit;
    logic [NUM_PORTS-1:0]             ack, ack_nxt;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_v;
    logic [NUM_PORTS-1:0][7:0]        wdata_v, rdata_v;

    logic last;       // port served by the previous SDRAM access
    logic gnt;        // port owning the access in flight
    logic gnt_nxt;
    logic take;       // latch a new command this cycle
    logic wait_done;  // controller finished the access in flight

    assign req_v   = {chr_req, prg_req};
    assign wren_v  = {chr_wren, prg_wren};
    assign addr_v  = {chr_addr, prg_addr};
    assign wdata_v = {chr_wdata, prg_wdata};

    assign prg_ack   = ack[0];
    assign chr_ack   = ack[1];
    assign prg_rdata = rdata_v[0];
    assign chr_rdata = rdata_v[1];

    assign wait_done = (state == WAIT) && mem_ready;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        sdram_port_slot #(.ADDR_W(ADDR_W)) u_slot (
            .clk_sys   (clk_sys),
            .rst       (rst),
            .req       (req_v[i]),
            .addr      (addr_v[i]),
            .wren      (wren_v[i]),
            .ack       (ack[i]),
            .fill      (wait_done && !mem_wren && (gnt == 1'(i))),
            .inval     (wait_done && mem_wren),
            .mem_addr  (mem_address),
            .fill_data (from_mem),
            .elig      (elig[i]),
            .hit       (hit[i]),
            .rdata     (rdata_v[i])
        );
    end

    always_ff @(posedge clk_sys) begin
        if (rst) state <= INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ack_nxt   = '0;
        gnt_nxt   = gnt;
        take      = 1'b0;
        case (state)
            INIT:   if (mem_ready) state_nxt = IDLE;
            IDLE: begin
                if (|hit) begin
                    // Hits never touch SDRAM; both ports may complete together.
                    ack_nxt = hit;
                end else if (mem_ready && (|elig)) begin
                    // Prefer the port that did not go last; fall back to the other.
                    gnt_nxt   = elig[~last] ? ~last : last;
                    take      = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ:    state_nxt = SETTLE;
            // Controller drops mem_ready a cycle late; a stale ready here is ignored.
            SETTLE: state_nxt = WAIT;
            WAIT: begin
                if (mem_ready) begin
                    ack_nxt[gnt] = 1'b1;
                    state_nxt    = DONE;
                end
            end
            DONE:   state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            rst_out     <= 1'b1;
            ack         <= '0;
            mem_req     <= 1'b0;
            mem_wren    <= 1'b0;
            mem_address <= '0;
            to_mem      <= '0;
            gnt         <= 1'b0;
            last        <= 1'b1;
        end else begin
            ack     <= ack_nxt;
            mem_req <= take;
            if (state == INIT && mem_ready) rst_out <= 1'b0;
            // Command fields hold between accesses; only mem_req qualifies them.
            if (take) begin
                gnt         <= gnt_nxt;
                mem_address <= addr_v[gnt_nxt];
                mem_wren    <= wren_v[gnt_nxt];
                to_mem      <= wdata_v[gnt_nxt];
            end
            if (state == DONE) last <= gnt;
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;
    localparam int ADDR_W = 21;

    logic              clk_sys = 1'b0;
    logic              rst = 1'b1;
    logic              rst_out;
    logic              prg_req = 1'b0, prg_wren = 1'b0;
    logic [ADDR_W-1:0] prg_addr = '0;
    logic [7:0]        prg_wdata = '0, prg_rdata;
    logic              prg_ack;
    logic              chr_req = 1'b0, chr_wren = 1'b0;
    logic [ADDR_W-1:0] chr_addr = '0;
    logic [7:0]        chr_wdata = '0, chr_rdata;
    logic              chr_ack;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_req, mem_wren;
    logic [7:0]        to_mem;
    logic [7:0]        from_mem = '0;
    logic              mem_ready = 1'b0;

    sdram_port_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk_sys(clk_sys), .rst(rst), .rst_out(rst_out),
        .prg_req(prg_req), .prg_addr(prg_addr), .prg_wren(prg_wren),
        .prg_wdata(prg_wdata), .prg_rdata(prg_rdata), .prg_ack(prg_ack),
        .chr_req(chr_req), .chr_addr(chr_addr), .chr_wren(chr_wren),
        .chr_wdata(chr_wdata), .chr_rdata(chr_rdata), .chr_ack(chr_ack),
        .mem_address(mem_address), .mem_req(mem_req), .mem_wren(mem_wren),
        .to_mem(to_mem), .from_mem(from_mem), .mem_ready(mem_ready)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    initial forever begin
        @(posedge clk_sys);
        cyc = cyc + 1;
    end

    // ---------------- controller model ----------------
    logic [7:0]        ctl_mem [int];
    logic [7:0]        ref_mem [int];
    bit                ctl_en = 1'b0;
    int                c_lat = 2, c_cnt = 0;
    logic [7:0]        c_pend = '0;
    int                mreq_count = 0, last_mreq_cyc = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic              last_wren = 1'b0;
    logic [7:0]        last_wdata = '0;
    logic [ADDR_W-1:0] mreq_log [$];

    function automatic logic [7:0] init_val(int a);
        return 8'(a * 37 + (a >> 7) + 13);
    endfunction
    function automatic logic [7:0] ctl_rd(int a);
        if (ctl_mem.exists(a)) return ctl_mem[a];
        return init_val(a);
    endfunction
    function automatic logic [7:0] ref_rd(logic [ADDR_W-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(int'(a));
    endfunction

    initial forever begin
        @(negedge clk_sys);
        if (rst) begin
            c_cnt = 0;
            mem_ready = ctl_en;
        end else begin
            if (mem_req) begin
                mreq_count++;
                last_addr = mem_address;
                last_wren = mem_wren;
                last_wdata = to_mem;
                last_mreq_cyc = cyc;
                mreq_log.push_back(mem_address);
            end
            if (c_cnt > 0) begin
                c_cnt--;
                if (c_cnt == 0) begin
                    mem_ready = 1'b1;
                    from_mem = c_pend;
                end
            end else if (mem_req) begin
                if (mem_wren) begin
                    ctl_mem[int'(mem_address)] = to_mem;
                    c_pend = 8'($urandom);
                end else begin
                    c_pend = ctl_rd(int'(mem_address));
                end
                from_mem = 8'($urandom);  // garbage until the access completes
                mem_ready = 1'b0;
                c_cnt = c_lat;
            end else begin
                mem_ready = ctl_en;
            end
        end
    end

    // ---------------- reference hit registers ----------------
    bit                m_valid [2];
    logic [ADDR_W-1:0] m_tag [2];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(int p, bit r, logic [ADDR_W-1:0] a, bit w, logic [7:0] d);
        if (p == 0) begin
            prg_req = r; prg_addr = a; prg_wren = w; prg_wdata = d;
        end else begin
            chr_req = r; chr_addr = a; chr_wren = w; chr_wdata = d;
        end
    endtask

    function automatic bit get_ack(int p);
        return (p == 0) ? prg_ack : chr_ack;
    endfunction
    function automatic logic [7:0] get_rd(int p);
        return (p == 0) ? prg_rdata : chr_rdata;
    endfunction

    task automatic chk_reset_vals(string tag);
        chk({tag, "_rst_out"}, 32'(rst_out), 1);
        chk({tag, "_mem_req"}, 32'(mem_req), 0);
        chk({tag, "_mem_wren"}, 32'(mem_wren), 0);
        chk({tag, "_mem_address"}, 32'(mem_address), 0);
        chk({tag, "_to_mem"}, 32'(to_mem), 0);
        chk({tag, "_acks"}, 32'({prg_ack, chr_ack}), 0);
        chk({tag, "_prg_rdata"}, 32'(prg_rdata), 0);
        chk({tag, "_chr_rdata"}, 32'(chr_rdata), 0);
    endtask

    // One access on one port, with the other port idle. Called at posedge+1.
    task automatic access(int p, logic [ADDR_W-1:0] a, bit w, logic [7:0] d);
        int c0, t0, lat;
        bit exp_hit, got;
        logic [7:0] rd0;
        c0 = mreq_count; lat = c_lat; rd0 = get_rd(p); t0 = cyc; got = 1'b0;
        exp_hit = !w && m_valid[p] && (m_tag[p] == a);
        drive(p, 1'b1, a, w, d);
        for (int k = 0; k < 60; k++) begin
            @(posedge clk_sys); #1;
            if (get_ack(p)) begin got = 1'b1; break; end
        end
        chk("ack_seen", 32'(got), 1);
        if (got) begin
            chk("other_ack_quiet", 32'(get_ack(1 - p)), 0);
            if (exp_hit) begin
                chk("hit_latency", 32'(cyc - t0), 1);
                chk("hit_no_mem_req", 32'(mreq_count), 32'(c0));
            end else begin
                chk("miss_mem_req_count", 32'(mreq_count), 32'(c0 + 1));
                chk("miss_mem_address", 32'(last_addr), 32'(a));
                chk("miss_mem_wren", 32'(last_wren), 32'(w));
                if (w) chk("miss_to_mem", 32'(last_wdata), 32'(d));
                chk("miss_ack_latency", 32'(cyc - last_mreq_cyc), 32'(((lat > 2) ? lat : 2) + 1));
            end
            if (w) chk("write_rdata_hold", 32'(get_rd(p)), 32'(rd0));
            else   chk("read_rdata", 32'(get_rd(p)), 32'(ref_rd(a)));
        end
        // req is still high through the ack cycle; it must not be served again.
        @(posedge clk_sys); #1;
        chk("no_repeat_ack", 32'(get_ack(p)), 0);
        drive(p, 1'b0, a, w, d);
        if (w) begin
            for (int q = 0; q < 2; q++) if (m_tag[q] == a) m_valid[q] = 1'b0;
            ref_mem[int'(a)] = d;
        end else begin
            m_valid[p] = 1'b1;
            m_tag[p] = a;
        end
    endtask

    // Back-to-back reads on one port, req held high and address changed on ack.
    task automatic stream(int p, logic [ADDR_W-1:0] base, logic [ADDR_W-1:0] step);
        logic [ADDR_W-1:0] a;
        bit got;
        a = base;
        for (int i = 0; i < 3; i++) begin
            a = base + ADDR_W'(i) * step;
            drive(p, 1'b1, a, 1'b0, 8'h00);
            got = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(posedge clk_sys); #1;
                if (get_ack(p)) begin got = 1'b1; break; end
            end
            chk("stream_ack", 32'(got), 1);
            if (got) chk("stream_rdata", 32'(get_rd(p)), 32'(ref_rd(a)));
        end
        @(posedge clk_sys); #1;
        drive(p, 1'b0, a, 1'b0, 8'h00);
        m_valid[p] = 1'b1;
        m_tag[p] = a;
    endtask

    logic [ADDR_W-1:0] pool [4];
    logic [ADDR_W-1:0] exp_order [6];

    initial begin
        bit got;
        pool[0] = 21'h00100; pool[1] = 21'h00101; pool[2] = 21'h1F000; pool[3] = 21'h0C123;
        exp_order[0] = 21'h00010; exp_order[1] = 21'h1E000;
        exp_order[2] = 21'h00014; exp_order[3] = 21'h1E010;
        exp_order[4] = 21'h00018; exp_order[5] = 21'h1E020;
        m_valid[0] = 1'b0; m_valid[1] = 1'b0; m_tag[0] = '0; m_tag[1] = '0;

        // Reset and init: controller not ready for 50 cycles.
        repeat (3) @(posedge clk_sys);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk_sys); #1;
            chk("init_rst_out_held", 32'(rst_out), 1);
        end
        chk("init_no_mem_req", 32'(mreq_count), 0);
        ctl_en = 1'b1;
        @(posedge clk_sys); #1;
        chk("init_rst_out_release", 32'(rst_out), 0);

        // Simultaneous requests: PRG first, then strict alternation.
        c_lat = 2;
        mreq_log.delete();
        fork
            stream(0, 21'h00010, 21'h00004);
            stream(1, 21'h1E000, 21'h00010);
        join
        chk("rr_grant_count", 32'(mreq_log.size()), 6);
        for (int i = 0; i < 6; i++)
            if (i < mreq_log.size()) chk("rr_grant_order", 32'(mreq_log[i]), 32'(exp_order[i]));

        // PRG read miss with four-cycle controller latency, then hit.
        ctl_mem[32'h0C123] = 8'h5A; ref_mem[32'h0C123] = 8'h5A;
        c_lat = 4;
        access(0, 21'h0C123, 1'b0, 8'h00);
        chk("prg_rdata_5a", 32'(prg_rdata), 32'h5A);
        access(0, 21'h0C123, 1'b0, 8'h00);

        // Write coherence across ports.
        ctl_mem[32'h1E004] = 8'h11; ref_mem[32'h1E004] = 8'h11;
        c_lat = 3;
        access(1, 21'h1E004, 1'b0, 8'h00);
        access(1, 21'h1E004, 1'b0, 8'h00);
        access(0, 21'h1E004, 1'b1, 8'h77);
        access(1, 21'h1E004, 1'b0, 8'h00);
        chk("chr_rdata_77", 32'(chr_rdata), 32'h77);

        // Write data path.
        access(0, 21'h06000, 1'b1, 8'hA5);
        chk("wr_mem_address", 32'(last_addr), 32'h06000);
        chk("wr_to_mem", 32'(last_wdata), 32'hA5);
        chk("wr_mem_wren", 32'(last_wren), 1);

        // Randomized traffic over a small address pool.
        for (int i = 0; i < 40; i++) begin
            c_lat = $urandom_range(1, 5);
            access($urandom_range(0, 1), pool[$urandom_range(0, 3)],
                   ($urandom_range(0, 2) == 0), 8'($urandom));
        end

        // Reset in the middle of an access.
        c_lat = 5;
        drive(0, 1'b1, 21'h00200, 1'b0, 8'h00);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk_sys); #1;
            if (mem_req) begin got = 1'b1; break; end
        end
        chk("midrst_mem_req_seen", 32'(got), 1);
        @(posedge clk_sys); #1;
        @(posedge clk_sys); #1;
        chk("midrst_ctl_busy", 32'(mem_ready), 0);
        rst = 1'b1;
        @(posedge clk_sys); #1;
        chk_reset_vals("midrst");
        drive(0, 1'b0, 21'h00200, 1'b0, 8'h00);
        @(posedge clk_sys); #1;
        chk("midrst_no_ack", 32'({prg_ack, chr_ack}), 0);
        rst = 1'b0;
        m_valid[0] = 1'b0; m_valid[1] = 1'b0;
        @(posedge clk_sys); #1;
        chk("midrst_rst_out_release", 32'(rst_out), 0);
        c_lat = 2;
        access(0, 21'h0C123, 1'b0, 8'h00);
        access(0, 21'h0C123, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            c_lat = $urandom_range(1, 4);
            access($urandom_range(0, 1), pool[$urandom_range(0, 3)],
                   ($urandom_range(0, 2) == 0), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
